image_ddr_writer: RTL and testbench
===================================

IMAGE_DDR_WRITER -- requirements
Module: image_ddr_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, 64-bit words per DDR3 write burst (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 28, DDR3 byte-address width.
REQ-003 SHALL have parameter BANK0_BASE, default 28'h000_0000, byte base address of frame bank 0.
REQ-004 SHALL have parameter BANK1_BASE, default 28'h080_0000, byte base address of frame bank 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, input buffer depth in words (power of two, at least 2*BURST_LEN).
REQ-006 SHALL have port clk_input, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port image_fifo_en, input, 1, pixel-word strobe from the image deserialiser.
REQ-009 SHALL have port image_data_ddr, input, 64, packed 8x8-bit pixel word, valid when image_fifo_en=1.
REQ-010 SHALL have port frame_end, input, 1, end-of-frame pulse.
REQ-011 SHALL have ports ddr_cmd_valid (output, 1), ddr_cmd_ready (input, 1) and ddr_cmd_addr (output, ADDR_W): write-command handshake.
REQ-012 SHALL have ports ddr_wr_valid (output, 1), ddr_wr_ready (input, 1), ddr_wr_data (output, 64) and ddr_wr_last (output, 1): write-data handshake.
REQ-013 SHALL have ports frame_done (output, 1), one-cycle pulse when a frame is fully written; frame_bank (output, 1), bank currently being filled; overflow (output, 1), sticky input-drop flag.

Function
REQ-014 SHALL write image_data_ddr into the internal FIFO on every cycle with image_fifo_en=1 and the FIFO not full; when the FIFO is full it SHALL drop the word and set overflow.
REQ-015 SHALL, on frame_end=1, set flush_pending; a frame_end while flush_pending is already set SHALL be ignored; a word strobed in the same cycle as frame_end SHALL be stored and belongs to the ending frame.
REQ-016 SHALL implement FSM states IDLE, CMD, DATA, PAD, DONE.
REQ-017 IDLE: SHALL go to CMD if fifo_count >= BURST_LEN, or if flush_pending=1 and fifo_count > 0; SHALL go to DONE if flush_pending=1 and fifo_count = 0; otherwise SHALL stay in IDLE.
REQ-018 CMD: SHALL hold ddr_cmd_valid=1 with ddr_cmd_addr=wr_addr, stable until ddr_cmd_ready=1, then go to DATA.
REQ-019 DATA: SHALL assert ddr_wr_valid=1 while the FIFO is non-empty, with ddr_wr_data = FIFO head (first-word-fall-through); each cycle with ddr_wr_valid=1 and ddr_wr_ready=1 SHALL pop one word and increment beat_cnt.
REQ-020 DATA: if the FIFO is empty, flush_pending=1 and beat_cnt < BURST_LEN, it SHALL go to PAD.
REQ-021 PAD: SHALL send 64'h0 words with ddr_wr_valid=1 until the burst holds exactly BURST_LEN beats.
REQ-022 SHALL assert ddr_wr_last on beat BURST_LEN-1 only.
REQ-023 After the last beat is accepted, SHALL set wr_addr = wr_addr + BURST_LEN*8 (modulo 2^ADDR_W), clear beat_cnt and go to IDLE.
REQ-024 DONE: SHALL pulse frame_done for 1 cycle, toggle frame_bank, load wr_addr with the new bank's base, clear flush_pending and return to IDLE.
REQ-025 ddr_wr_valid and ddr_cmd_valid SHALL never be high in the same cycle.
REQ-026 Latency: with both readies held at 1, ddr_cmd_valid SHALL rise 2 cycles after the strobe that makes fifo_count reach BURST_LEN.
REQ-027 A frame with zero words (frame_end with an empty FIFO) SHALL produce frame_done and a bank toggle with no DDR traffic.

Reset
REQ-028 While reset=1, SHALL hold: FSM=IDLE, FIFO empty, wr_addr=BANK0_BASE, frame_bank=0, flush_pending=0, beat_cnt=0, and all outputs at 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately; no completion or padding SHALL follow deassertion.
REQ-030 overflow SHALL clear only on reset.

Structure
REQ-031 A shared package image_pkg SHALL hold the FSM state encoding, the default bank base addresses and the word width (64).
REQ-032 The input buffer SHALL be one sub-module, sync_fwft_fifo (parameterised width and depth, with count, full and empty outputs).

Verification
REQ-033 24 strobes (data = index), both readies held at 1, then frame_end -> 3 bursts at addresses 0x0, 0x40, 0x80, then frame_done, frame_bank=1.
REQ-034 11 strobes, then frame_end -> 2 bursts; beats 4..8 of the second burst are 64'h0; ddr_wr_last on beat 8 of each burst.
REQ-035 ddr_wr_ready toggled every other cycle -> data order preserved, no duplicates, each burst exactly 8 beats.
REQ-036 ddr_cmd_ready held at 0 while 40 strobes arrive -> 32 words stored, overflow=1, words 33..40 absent from DDR output.
REQ-037 frame_end with an empty FIFO -> frame_done pulse, frame_bank toggles, next burst address is 0x0800000.
REQ-038 reset asserted on beat 3 of a burst -> all outputs 0 immediately; after release, the first command address is 0x0.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the image-to-DDR3 write path.
//   WORD_W          : width of one packed pixel word / DDR3 data beat
//   DEF_BANK0_BASE  : default byte base address of frame bank 0
//   DEF_BANK1_BASE  : default byte base address of frame bank 1
//   wr_state_e      : burst-writer FSM state encoding
package image_pkg;

  localparam int unsigned WORD_W = 64;

  localparam logic [27:0] DEF_BANK0_BASE = 28'h000_0000;
  localparam logic [27:0] DEF_BANK1_BASE = 28'h080_0000;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StPad,
    StDone
  } wr_state_e;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk_input, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data  : write strobe and data; ignored when full
//   pop              : consume the head word; ignored when empty
//   head             : current head word, valid whenever empty=0
//   count            : number of stored words (0..DEPTH)
//   full, empty      : status flags
module sync_fwft_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_input,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_input) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/image_ddr_writer.sv
// Buffers 64-bit pixel words and writes them to DDR3 as fixed-length bursts,
// ping-ponging between two frame banks.
//   clk_input, reset          : clock, asynchronous active-high reset
//   image_fifo_en/_data_ddr   : pixel-word strobe and data
//   frame_end                 : end-of-frame pulse; flushes a partial burst (zero padded)
//   ddr_cmd_valid/ready/addr  : write-command handshake
//   ddr_wr_valid/ready/data/last : write-data handshake
//   frame_done                : one-cycle pulse when a frame is fully written
//   frame_bank                : bank currently being filled
//   overflow                  : sticky, set when a word is dropped on a full buffer
module image_ddr_writer
  import image_pkg::*;
#(
  parameter int unsigned       BURST_LEN  = 8,
  parameter int unsigned       ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(DEF_BANK0_BASE),
  parameter logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(DEF_BANK1_BASE),
  parameter int unsigned       FIFO_DEPTH = 32
) (
  input  logic              clk_input,
  input  logic              reset,
  input  logic              image_fifo_en,
  input  logic [WORD_W-1:0] image_data_ddr,
  input  logic              frame_end,
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic [ADDR_W-1:0] ddr_cmd_addr,
  output logic              ddr_wr_valid,
  input  logic              ddr_wr_ready,
  output logic [WORD_W-1:0] ddr_wr_data,
  output logic              ddr_wr_last,
  output logic              frame_done,
  output logic              frame_bank,
  output logic              overflow
);

  localparam int unsigned       CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned       BEAT_W      = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 8);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              bank_q, bank_d;
  logic              flush_q, flush_d;
  logic              overflow_q, overflow_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  sync_fwft_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_input (clk_input),
    .reset     (reset),
    .push      (image_fifo_en),
    .push_data (image_data_ddr),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign overflow_d = overflow_q | (image_fifo_en & fifo_full);
  assign frame_bank = bank_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    beat_cnt_d = beat_cnt_q;
    bank_d     = bank_q;
    // A frame_end while a flush is already pending is absorbed by the OR.
    flush_d    = flush_q | frame_end;

    ddr_cmd_valid = 1'b0;
    ddr_cmd_addr  = '0;
    ddr_wr_valid  = 1'b0;
    ddr_wr_data   = '0;
    ddr_wr_last   = 1'b0;
    frame_done    = 1'b0;
    fifo_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fifo_count >= BURST_CNT || (flush_q && !fifo_empty)) begin
          state_d = StCmd;
        end else if (flush_q) begin
          state_d = StDone;
        end
      end

      StCmd: begin
        ddr_cmd_valid = 1'b1;
        ddr_cmd_addr  = wr_addr_q;
        if (ddr_cmd_ready) state_d = StData;
      end

      StData: begin
        if (!fifo_empty) begin
          ddr_wr_valid = 1'b1;
          ddr_wr_data  = fifo_head;
          ddr_wr_last  = (beat_cnt_q == LAST_BEAT);
          if (ddr_wr_ready) begin
            fifo_pop = 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              wr_addr_d  = wr_addr_q + BURST_BYTES;
              beat_cnt_d = '0;
              state_d    = StIdle;
            end else begin
              beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
          end
        end else if (flush_q) begin
          // Frame tail is shorter than a burst: complete it with zeros.
          state_d = StPad;
        end
      end

      StPad: begin
        ddr_wr_valid = 1'b1;
        ddr_wr_last  = (beat_cnt_q == LAST_BEAT);
        if (ddr_wr_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            wr_addr_d  = wr_addr_q + BURST_BYTES;
            beat_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      StDone: begin
        frame_done = 1'b1;
        bank_d     = ~bank_q;
        wr_addr_d  = bank_q ? BANK0_BASE : BANK1_BASE;
        flush_d    = 1'b0;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_addr_q  <= BANK0_BASE;
      beat_cnt_q <= '0;
      bank_q     <= 1'b0;
      flush_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      beat_cnt_q <= beat_cnt_d;
      bank_q     <= bank_d;
      flush_q    <= flush_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_image_ddr_writer.sv
module tb_image_ddr_writer;

  localparam int unsigned ADDR_W = 28;

  logic              clk_input = 1'b0;
  logic              reset = 1'b1;
  logic              image_fifo_en = 1'b0;
  logic [63:0]       image_data_ddr = '0;
  logic              frame_end = 1'b0;
  logic              ddr_cmd_ready = 1'b0;
  logic              ddr_wr_ready = 1'b0;
  logic              ddr_cmd_valid;
  logic [ADDR_W-1:0] ddr_cmd_addr;
  logic              ddr_wr_valid;
  logic [63:0]       ddr_wr_data;
  logic              ddr_wr_last;
  logic              frame_done;
  logic              frame_bank;
  logic              overflow;

  image_ddr_writer dut (
    .clk_input      (clk_input),
    .reset          (reset),
    .image_fifo_en  (image_fifo_en),
    .image_data_ddr (image_data_ddr),
    .frame_end      (frame_end),
    .ddr_cmd_valid  (ddr_cmd_valid),
    .ddr_cmd_ready  (ddr_cmd_ready),
    .ddr_cmd_addr   (ddr_cmd_addr),
    .ddr_wr_valid   (ddr_wr_valid),
    .ddr_wr_ready   (ddr_wr_ready),
    .ddr_wr_data    (ddr_wr_data),
    .ddr_wr_last    (ddr_wr_last),
    .frame_done     (frame_done),
    .frame_bank     (frame_bank),
    .overflow       (overflow)
  );

  always #5 clk_input = ~clk_input;

  int checks = 0;
  int errors = 0;

  // Bus monitor: samples mid-cycle, records accepted commands/beats.
  logic [ADDR_W-1:0] cmd_q[$];
  logic [63:0]       data_q[$];
  logic              last_q[$];
  int                rise_q[$];
  int                strobe_q[$];
  int                done_cnt = 0;
  int                excl_viol = 0;
  int                cyc = 0;
  logic              prev_cmd_valid = 1'b0;

  always @(negedge clk_input) begin
    cyc <= cyc + 1;
    prev_cmd_valid <= ddr_cmd_valid;
    if (image_fifo_en) strobe_q.push_back(cyc);
    if (ddr_cmd_valid && !prev_cmd_valid) rise_q.push_back(cyc);
    if (ddr_cmd_valid && ddr_cmd_ready) cmd_q.push_back(ddr_cmd_addr);
    if (ddr_wr_valid && ddr_wr_ready) begin
      data_q.push_back(ddr_wr_data);
      last_q.push_back(ddr_wr_last);
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (ddr_cmd_valid && ddr_wr_valid) excl_viol <= excl_viol + 1;
  end

  task automatic do_reset();
    reset = 1'b1;
    image_fifo_en = 1'b0;
    frame_end = 1'b0;
    image_data_ddr = '0;
    ddr_cmd_ready = 1'b0;
    ddr_wr_ready = 1'b0;
    repeat (2) @(posedge clk_input);
    #1 reset = 1'b0;
  endtask

  // n strobes (data = base + index), optional frame_end pulse right after, then tail idle cycles.
  task automatic drive_frame(input int n, input logic [63:0] base, input bit throttle,
                             input bit send_end, input int tail);
    for (int c = 0; c < n + 1 + tail; c++) begin
      @(posedge clk_input);
      #1;
      image_fifo_en  = (c < n);
      image_data_ddr = (c < n) ? base + 64'(c) : 64'h0;
      frame_end      = send_end && (c == n);
      if (throttle) ddr_wr_ready = c[0];
    end
    @(posedge clk_input);
    #1;
    image_fifo_en  = 1'b0;
    image_data_ddr = '0;
    frame_end      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk_input);
      #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ddr_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", ddr_cmd_valid); end
    checks++; if (ddr_cmd_addr !== '0) begin errors++; $display("FAIL reset_cmd_addr: got %h want 0", ddr_cmd_addr); end
    checks++; if (ddr_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", ddr_wr_valid); end
    checks++; if (ddr_wr_data !== 64'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", ddr_wr_data); end
    checks++; if (ddr_wr_last !== 1'b0) begin errors++; $display("FAIL reset_wr_last: got %b want 0", ddr_wr_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (frame_bank !== 1'b0) begin errors++; $display("FAIL reset_frame_bank: got %b want 0", frame_bank); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    do_reset();
  endtask

  task automatic test_full_frame();
    int c0 = cmd_q.size(), d0 = data_q.size(), r0 = rise_q.size(), s0 = strobe_q.size();
    int f0 = done_cnt;
    bit ok;
    logic [ADDR_W-1:0] exp_a;
    ddr_cmd_ready = 1'b1;
    ddr_wr_ready  = 1'b1;
    drive_frame(24, 64'h0, 1'b0, 1'b1, 0);
    wait_done(f0 + 1, 300, ok);
    repeat (2) @(posedge clk_input);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout: got no frame_done want pulse"); end
    checks++; if (cmd_q.size() - c0 != 3) begin errors++; $display("FAIL full_cmd_count: got %0d want 3", cmd_q.size() - c0); end
    for (int k = 0; k < 3; k++) begin
      exp_a = ADDR_W'(k * 64);
      if (cmd_q.size() > c0 + k) begin
        checks++; if (cmd_q[c0+k] !== exp_a) begin errors++; $display("FAIL full_cmd_addr%0d: got %h want %h", k, cmd_q[c0+k], exp_a); end
      end
    end
    checks++; if (data_q.size() - d0 != 24) begin errors++; $display("FAIL full_beat_count: got %0d want 24", data_q.size() - d0); end
    for (int i = 0; i < 24; i++) begin
      if (data_q.size() > d0 + i) begin
        checks++; if (data_q[d0+i] !== 64'(i)) begin errors++; $display("FAIL full_data%0d: got %h want %h", i, data_q[d0+i], 64'(i)); end
        checks++; if (last_q[d0+i] !== ((i % 8) == 7)) begin errors++; $display("FAIL full_last%0d: got %b want %b", i, last_q[d0+i], (i % 8) == 7); end
      end
    end
    if (rise_q.size() > r0 && strobe_q.size() > s0 + 7) begin
      checks++; if (rise_q[r0] - strobe_q[s0+7] != 2) begin errors++; $display("FAIL cmd_latency: got %0d want 2", rise_q[r0] - strobe_q[s0+7]); end
    end else begin
      checks++; errors++; $display("FAIL cmd_latency: got no command or strobe record want latency 2");
    end
    checks++; if (frame_bank !== 1'b1) begin errors++; $display("FAIL full_frame_bank: got %b want 1", frame_bank); end
    checks++; if (done_cnt - f0 != 1) begin errors++; $display("FAIL full_done_pulse: got %0d cycles want 1", done_cnt - f0); end
  endtask

  task automatic test_partial_frame();
    int c0, d0, f0;
    bit ok;
    logic [63:0] exp_d;
    do_reset();
    c0 = cmd_q.size(); d0 = data_q.size(); f0 = done_cnt;
    ddr_cmd_ready = 1'b1;
    ddr_wr_ready  = 1'b1;
    drive_frame(11, 64'd100, 1'b0, 1'b1, 0);
    wait_done(f0 + 1, 300, ok);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL partial_done_timeout: got no frame_done want pulse"); end
    checks++; if (cmd_q.size() - c0 != 2) begin errors++; $display("FAIL partial_cmd_count: got %0d want 2", cmd_q.size() - c0); end
    if (cmd_q.size() > c0 + 1) begin
      checks++; if (cmd_q[c0+1] !== 28'h40) begin errors++; $display("FAIL partial_cmd_addr1: got %h want 40", cmd_q[c0+1]); end
    end
    checks++; if (data_q.size() - d0 != 16) begin errors++; $display("FAIL partial_beat_count: got %0d want 16", data_q.size() - d0); end
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 11) ? 64'd100 + 64'(i) : 64'h0;
      if (data_q.size() > d0 + i) begin
        checks++; if (data_q[d0+i] !== exp_d) begin errors++; $display("FAIL partial_data%0d: got %h want %h", i, data_q[d0+i], exp_d); end
        checks++; if (last_q[d0+i] !== ((i % 8) == 7)) begin errors++; $display("FAIL partial_last%0d: got %b want %b", i, last_q[d0+i], (i % 8) == 7); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, d0, f0;
    bit ok;
    do_reset();
    c0 = cmd_q.size(); d0 = data_q.size(); f0 = done_cnt;
    ddr_cmd_ready = 1'b1;
    drive_frame(16, 64'd200, 1'b1, 1'b1, 80);
    ddr_wr_ready = 1'b1;
    wait_done(f0 + 1, 100, ok);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL throttle_done_timeout: got no frame_done want pulse"); end
    checks++; if (cmd_q.size() - c0 != 2) begin errors++; $display("FAIL throttle_cmd_count: got %0d want 2", cmd_q.size() - c0); end
    checks++; if (data_q.size() - d0 != 16) begin errors++; $display("FAIL throttle_beat_count: got %0d want 16", data_q.size() - d0); end
    for (int i = 0; i < 16; i++) begin
      if (data_q.size() > d0 + i) begin
        checks++; if (data_q[d0+i] !== 64'd200 + 64'(i)) begin errors++; $display("FAIL throttle_data%0d: got %h want %h", i, data_q[d0+i], 64'd200 + 64'(i)); end
        checks++; if (last_q[d0+i] !== ((i % 8) == 7)) begin errors++; $display("FAIL throttle_last%0d: got %b want %b", i, last_q[d0+i], (i % 8) == 7); end
      end
    end
  endtask

  task automatic test_overflow();
    int c0, d0, f0;
    bit ok;
    logic [ADDR_W-1:0] exp_a;
    do_reset();
    c0 = cmd_q.size(); d0 = data_q.size(); f0 = done_cnt;
    ddr_wr_ready = 1'b1;
    drive_frame(40, 64'd300, 1'b0, 1'b0, 2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (data_q.size() != d0) begin errors++; $display("FAIL ovf_no_beats: got %0d beats want 0", data_q.size() - d0); end
    checks++; if (ddr_cmd_valid !== 1'b1) begin errors++; $display("FAIL ovf_cmd_wait: got %b want 1", ddr_cmd_valid); end
    ddr_cmd_ready = 1'b1;
    drive_frame(0, 64'h0, 1'b0, 1'b1, 0);
    wait_done(f0 + 1, 300, ok);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout: got no frame_done want pulse"); end
    checks++; if (cmd_q.size() - c0 != 4) begin errors++; $display("FAIL ovf_cmd_count: got %0d want 4", cmd_q.size() - c0); end
    for (int k = 0; k < 4; k++) begin
      exp_a = ADDR_W'(k * 64);
      if (cmd_q.size() > c0 + k) begin
        checks++; if (cmd_q[c0+k] !== exp_a) begin errors++; $display("FAIL ovf_cmd_addr%0d: got %h want %h", k, cmd_q[c0+k], exp_a); end
      end
    end
    checks++; if (data_q.size() - d0 != 32) begin errors++; $display("FAIL ovf_beat_count: got %0d want 32", data_q.size() - d0); end
    for (int i = 0; i < 32; i++) begin
      if (data_q.size() > d0 + i) begin
        checks++; if (data_q[d0+i] !== 64'd300 + 64'(i)) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, data_q[d0+i], 64'd300 + 64'(i)); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_empty_frame();
    int c0, d0, f0;
    bit ok;
    do_reset();
    c0 = cmd_q.size(); d0 = data_q.size(); f0 = done_cnt;
    ddr_cmd_ready = 1'b1;
    ddr_wr_ready  = 1'b1;
    drive_frame(0, 64'h0, 1'b0, 1'b1, 0);
    wait_done(f0 + 1, 50, ok);
    repeat (2) @(posedge clk_input);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL empty_done_timeout: got no frame_done want pulse"); end
    checks++; if (done_cnt - f0 != 1) begin errors++; $display("FAIL empty_done_pulse: got %0d cycles want 1", done_cnt - f0); end
    checks++; if (frame_bank !== 1'b1) begin errors++; $display("FAIL empty_frame_bank: got %b want 1", frame_bank); end
    checks++; if (cmd_q.size() != c0 || data_q.size() != d0) begin errors++; $display("FAIL empty_no_traffic: got %0d cmds %0d beats want 0 0", cmd_q.size() - c0, data_q.size() - d0); end
    drive_frame(8, 64'd400, 1'b0, 1'b0, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_input);
      #1;
      if (cmd_q.size() > c0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bank1_cmd_timeout: got no command want one"); end
    else begin
      checks++; if (cmd_q[c0] !== 28'h080_0000) begin errors++; $display("FAIL bank1_cmd_addr: got %h want 0800000", cmd_q[c0]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int c0, d0, f0;
    bit ok;
    do_reset();
    c0 = cmd_q.size(); d0 = data_q.size(); f0 = done_cnt;
    ddr_cmd_ready = 1'b1;
    ddr_wr_ready  = 1'b1;
    drive_frame(8, 64'd500, 1'b0, 1'b0, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (data_q.size() >= d0 + 3) begin ok = 1'b1; break; end
      @(posedge clk_input);
      #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_burst_timeout: got %0d beats want 3", data_q.size() - d0); end
    checks++; if (ddr_wr_valid !== 1'b1 || ddr_wr_data !== 64'd503) begin errors++; $display("FAIL midrst_beat3: got valid=%b data=%h want valid=1 data=%h", ddr_wr_valid, ddr_wr_data, 64'd503); end
    reset = 1'b1;
    #1;
    checks++; if ({ddr_cmd_valid, ddr_wr_valid, ddr_wr_last, frame_done, frame_bank, overflow} !== 6'b0 || ddr_wr_data !== 64'h0 || ddr_cmd_addr !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got cv=%b wv=%b wl=%b fd=%b fb=%b ov=%b wd=%h ca=%h want all 0", ddr_cmd_valid, ddr_wr_valid, ddr_wr_last, frame_done, frame_bank, overflow, ddr_wr_data, ddr_cmd_addr);
    end
    repeat (2) @(posedge clk_input);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_input);
    #1;
    checks++; if (data_q.size() != d0 + 3 || done_cnt != f0) begin errors++; $display("FAIL midrst_abandon: got %0d beats %0d done want 3 0", data_q.size() - d0, done_cnt - f0); end
    c0 = cmd_q.size(); d0 = data_q.size();
    drive_frame(8, 64'd600, 1'b0, 1'b0, 0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (data_q.size() >= d0 + 8) begin ok = 1'b1; break; end
      @(posedge clk_input);
      #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reburst_timeout: got %0d beats want 8", data_q.size() - d0); end
    if (cmd_q.size() > c0) begin
      checks++; if (cmd_q[c0] !== '0) begin errors++; $display("FAIL midrst_cmd_addr: got %h want 0", cmd_q[c0]); end
    end
    for (int i = 0; i < 8; i++) begin
      if (data_q.size() > d0 + i) begin
        checks++; if (data_q[d0+i] !== 64'd600 + 64'(i)) begin errors++; $display("FAIL midrst_data%0d: got %h want %h", i, data_q[d0+i], 64'd600 + 64'(i)); end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (excl_viol != 0) begin errors++; $display("FAIL valid_exclusive: got %0d overlap cycles want 0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_frame();
    test_back_to_back();
    test_overflow();
    test_empty_frame();
    test_reset_mid_burst();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
